// File: rtl/q_meter.sv
// Ring-down Q meter: settles, excites the resonator, then counts oscillation
// cycles until the envelope comparator drops and publishes the saturated count.
module q_meter #(
    parameter int BUS_WIDTH      = 10,
    parameter int EXCITE_CYCLES  = 256,
    parameter int SETTLE_CYCLES  = 1024,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [BUS_WIDTH-1:0] i_ref,
    input  logic                 osc_in,
    input  logic                 env_above,
    output logic                 drive_en,
    output logic [BUS_WIDTH-1:0] q_measured,
    output logic                 ready,
    output logic                 timeout
);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        EXCITE,
        RING,
        DONE
    } state_t;

    localparam logic [CNT_WIDTH-1:0] SETTLE_LAST  = CNT_WIDTH'(SETTLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] EXCITE_LAST  = CNT_WIDTH'(EXCITE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [BUS_WIDTH-1:0] RING_MAX     = {BUS_WIDTH{1'b1}};

    state_t               state;
    state_t               state_nxt;
    logic [CNT_WIDTH-1:0] timer;
    logic [CNT_WIDTH-1:0] timer_nxt;
    logic [BUS_WIDTH-1:0] ring_cnt;
    logic [BUS_WIDTH-1:0] ring_cnt_nxt;
    logic                 timed_out;
    logic                 timed_out_nxt;

    logic                 osc_p0;
    logic                 osc_p1;
    logic                 osc_p2;
    logic                 env_p0;
    logic                 env_p1;
    logic [BUS_WIDTH-1:0] ref_shadow;

    logic                 osc_rise;
    logic                 ref_changed;
    logic                 timer_hit;
    logic                 publish;

    function automatic logic [BUS_WIDTH-1:0] sat_inc(input logic [BUS_WIDTH-1:0] v);
        return (v == RING_MAX) ? v : v + 1'b1;
    endfunction

    // Stage p0/p1: two-flop synchronizers; osc_p2 holds the previous synchronized sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            osc_p0     <= 1'b0;
            osc_p1     <= 1'b0;
            osc_p2     <= 1'b0;
            env_p0     <= 1'b0;
            env_p1     <= 1'b0;
            ref_shadow <= '0;
        end else begin
            osc_p0     <= osc_in;
            osc_p1     <= osc_p0;
            osc_p2     <= osc_p1;
            env_p0     <= env_above;
            env_p1     <= env_p0;
            ref_shadow <= i_ref;
        end
    end

    assign osc_rise    = osc_p1 & ~osc_p2;
    assign ref_changed = (i_ref != ref_shadow);
    assign timer_hit   = (timer == TIMEOUT_LAST);
    assign publish     = (state == DONE) && enable;

    always_comb begin
        state_nxt     = state;
        timer_nxt     = timer;
        ring_cnt_nxt  = ring_cnt;
        timed_out_nxt = timed_out;

        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = SETTLE;
                    timer_nxt = '0;
                end
            end
            SETTLE: begin
                if (timer == SETTLE_LAST) begin
                    state_nxt = EXCITE;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            EXCITE: begin
                if (timer == EXCITE_LAST) begin
                    state_nxt    = RING;
                    timer_nxt    = '0;
                    ring_cnt_nxt = '0;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            RING: begin
                timer_nxt = timer + 1'b1;
                // An edge landing on the exit cycle still counts
                if (osc_rise) begin
                    ring_cnt_nxt = sat_inc(ring_cnt);
                end
                if (!env_p1 || timer_hit) begin
                    state_nxt     = DONE;
                    timer_nxt     = '0;
                    timed_out_nxt = timer_hit;
                end
            end
            DONE: begin
                state_nxt = SETTLE;
                timer_nxt = '0;
            end
            default: begin
                state_nxt = IDLE;
                timer_nxt = '0;
            end
        endcase

        // A reference change restarts settling; DONE is allowed to finish first
        if (ref_changed && (state == SETTLE || state == EXCITE || state == RING)) begin
            state_nxt = SETTLE;
            timer_nxt = '0;
        end

        // Dropping enable wins over everything else
        if (!enable && state != IDLE) begin
            state_nxt = IDLE;
            timer_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            timer     <= '0;
            ring_cnt  <= '0;
            timed_out <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            ring_cnt  <= ring_cnt_nxt;
            timed_out <= timed_out_nxt;
        end
    end

    // Outputs are registered; drive_en follows the next state so it drops on the RING edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drive_en   <= 1'b0;
            ready      <= 1'b0;
            q_measured <= '0;
            timeout    <= 1'b0;
        end else begin
            drive_en <= (state_nxt == EXCITE);
            ready    <= publish;
            if (publish) begin
                q_measured <= ring_cnt;
                timeout    <= timed_out;
            end
        end
    end

endmodule

// File: tb/tb_q_meter.sv
// Directed bench for q_meter: a full-width instance and a 4-bit instance share stimulus.
module tb_q_meter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [9:0] i_ref;
    logic       osc_in;
    logic       env_above;
    logic       drive_en;
    logic [9:0] q_measured;
    logic       ready;
    logic       timeout;
    logic       drive_en_s;
    logic [3:0] q_measured_s;
    logic       ready_s;
    logic       timeout_s;

    always #5 clk = ~clk;

    q_meter #(.TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .i_ref(i_ref),
        .osc_in(osc_in), .env_above(env_above), .drive_en(drive_en),
        .q_measured(q_measured), .ready(ready), .timeout(timeout)
    );

    q_meter #(.BUS_WIDTH(4), .TIMEOUT_CYCLES(100)) dut_sat (
        .clk(clk), .rst_n(rst_n), .enable(enable), .i_ref(i_ref[3:0]),
        .osc_in(osc_in), .env_above(env_above), .drive_en(drive_en_s),
        .q_measured(q_measured_s), .ready(ready_s), .timeout(timeout_s)
    );

    typedef struct {
        int n;
        bit fall;
        bit pre_low;
        bit coincide;
        int exp_q;
        int exp_qs;
        bit exp_to;
    } vec_t;

    vec_t vecs[7];

    int   n_checks   = 0;
    int   n_pass     = 0;
    int   cyc        = 0;
    int   n_ready    = 0;
    int   last_ready = -1;
    int   hi_len     = 0;
    int   last_hi_len = 0;
    logic ready_q    = 1'b0;
    logic drive_q    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic wait_drive(input logic val, input int limit, input string name);
        int k = 0;
        while (drive_en !== val && k < limit) begin
            @(negedge clk);
            k++;
        end
        check(name, drive_en, val);
    endtask

    task automatic wait_ready(input int limit, input string name);
        int k = 0;
        while (ready !== 1'b1 && k < limit) begin
            @(negedge clk);
            k++;
        end
        check(name, ready, 1'b1);
    endtask

    task automatic pulses(input int n);
        for (int p = 0; p < n; p++) begin
            osc_in = 1'b1;
            @(negedge clk);
            osc_in = 1'b0;
            @(negedge clk);
        end
    endtask

    initial forever @(posedge clk) cyc++;

    // Strobe shape, spacing, instance alignment and excitation length
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            last_ready = -1;
            ready_q    = 1'b0;
            drive_q    = 1'b0;
            hi_len     = 0;
        end else begin
            if (ready) begin
                check("ready_single_cycle", ready_q, 1'b0);
                check("ready_sat_aligned", ready_s, 1'b1);
                if (last_ready >= 0) check("ready_spacing_min", (cyc - last_ready) >= 1282, 1'b1);
                last_ready = cyc;
                n_ready++;
            end
            if (drive_en) hi_len++;
            else if (drive_q) begin
                last_hi_len = hi_len;
                hi_len = 0;
            end
            ready_q = ready;
            drive_q = drive_en;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time exceeded, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t_ring, t_drop, nr, r;

        vecs[0] = '{37, 1'b1, 1'b0, 1'b0, 37, 15, 1'b0};
        vecs[1] = '{20, 1'b1, 1'b0, 1'b0, 20, 15, 1'b0};
        vecs[2] = '{12, 1'b0, 1'b0, 1'b0, 12, 12, 1'b1};
        vecs[3] = '{5,  1'b1, 1'b0, 1'b0, 5,  5,  1'b0};
        vecs[4] = '{0,  1'b1, 1'b1, 1'b0, 0,  0,  1'b0};
        vecs[5] = '{9,  1'b1, 1'b0, 1'b1, 9,  9,  1'b0};
        vecs[6] = '{16, 1'b1, 1'b0, 1'b0, 16, 15, 1'b0};

        rst_n = 1'b0; enable = 1'b0; osc_in = 1'b0; env_above = 1'b1; i_ref = 10'd10;
        repeat (3) @(negedge clk);
        check("rst_drive_en", drive_en, 1'b0);
        check("rst_q", q_measured, 0);
        check("rst_ready", ready, 1'b0);
        check("rst_timeout", timeout, 1'b0);
        check("rst_q_sat", q_measured_s, 0);

        rst_n = 1'b1; enable = 1'b1; t0 = cyc;
        wait_drive(1'b1, 2000, "first_drive_rise");
        check("first_settle_latency", cyc - t0, 1025);

        for (int i = 0; i < 7; i++) begin
            wait_drive(1'b1, 2000, "vec_drive_rise");
            if (vecs[i].pre_low) env_above = 1'b0;
            wait_drive(1'b0, 400, "vec_drive_fall");
            t_ring = cyc;
            t_drop = cyc;
            for (int p = 0; p < vecs[i].n; p++) begin
                osc_in = 1'b1;
                if (vecs[i].coincide && p == vecs[i].n - 1) begin
                    env_above = 1'b0;
                    t_drop = cyc;
                end
                @(negedge clk);
                osc_in = 1'b0;
                @(negedge clk);
            end
            if (vecs[i].fall && !vecs[i].pre_low && !vecs[i].coincide) begin
                env_above = 1'b0;
                t_drop = cyc;
            end
            wait_ready(300, "vec_ready");
            check("vec_q", q_measured, vecs[i].exp_q);
            check("vec_q_sat", q_measured_s, vecs[i].exp_qs);
            check("vec_timeout", timeout, vecs[i].exp_to);
            check("vec_timeout_sat", timeout_s, vecs[i].exp_to);
            if (vecs[i].pre_low) check("vec_latency_prelow", cyc - t_ring, 2);
            else if (vecs[i].fall) check("vec_latency_env", cyc - t_drop, 4);
            else check("vec_latency_timeout", cyc - t_ring, 101);
            check("vec_excite_len", last_hi_len, 256);
            env_above = 1'b1;
            osc_in = 1'b0;
        end

        // Reference change in the middle of excitation
        wait_drive(1'b1, 2000, "abort_drive_rise");
        repeat (50) @(negedge clk);
        i_ref = 10'd11; t0 = cyc; nr = n_ready;
        @(negedge clk);
        check("abort_drive_drop", drive_en, 1'b0);
        wait_drive(1'b1, 2000, "abort_drive_rerise");
        check("abort_settle_latency", cyc - t0, 1025);
        check("abort_no_ready", n_ready, nr);
        check("abort_q_hold", q_measured, 16);
        check("abort_q_sat_hold", q_measured_s, 15);

        // Enable dropped during ring-down
        wait_drive(1'b0, 400, "dis_ring_entry");
        pulses(3);
        enable = 1'b0; nr = n_ready;
        @(negedge clk);
        check("dis_drive_low", drive_en, 1'b0);
        repeat (200) @(negedge clk);
        check("dis_no_ready", n_ready, nr);
        check("dis_q_hold", q_measured, 16);
        check("dis_timeout_hold", timeout, 1'b0);
        check("dis_drive_idle", drive_en, 1'b0);
        enable = 1'b1; t0 = cyc;
        wait_drive(1'b1, 2000, "reen_drive_rise");
        check("reen_settle_latency", cyc - t0, 1025);
        wait_drive(1'b0, 400, "reen_ring_entry");
        pulses(3);
        env_above = 1'b0;
        wait_ready(300, "reen_ready");
        check("reen_q", q_measured, 3);
        check("reen_timeout", timeout, 1'b0);

        // Envelope held low: back-to-back measurements at minimum spacing
        r = cyc;
        @(negedge clk);
        wait_ready(2000, "min_spacing_ready");
        check("min_spacing_exact", cyc - r, 1282);
        check("min_spacing_q", q_measured, 0);
        env_above = 1'b1;

        wait_drive(1'b0, 2000, "pre_rst_drive_cycle");
        wait_drive(1'b1, 2000, "pre_rst_drive_rise");
        wait_drive(1'b0, 400, "pre_rst_ring_entry");
        pulses(4);
        env_above = 1'b0;
        wait_ready(300, "pre_rst_ready");
        check("pre_rst_q", q_measured, 4);
        env_above = 1'b1;

        // Asynchronous reset in the middle of ring-down
        wait_drive(1'b1, 2000, "rst_ring_drive_rise");
        wait_drive(1'b0, 400, "rst_ring_entry");
        pulses(2);
        rst_n = 1'b0;
        #1;
        check("async_rst_q", q_measured, 0);
        check("async_rst_drive", drive_en, 1'b0);
        check("async_rst_ready", ready, 1'b0);
        check("async_rst_timeout", timeout, 1'b0);
        repeat (3) @(negedge clk);
        check("async_rst_q_sat", q_measured_s, 0);
        rst_n = 1'b1; t0 = cyc;
        wait_drive(1'b1, 2000, "post_rst_drive_rise");
        check("post_rst_settle_latency", cyc - t0, 1025);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
